johnson_step_ctrl: RTL

//  Controller that sequences a WIDTH-stage Johnson ring (2*WIDTH states) for a commanded number of steps.

---
 rtl/johnson_step_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/johnson_step_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_step_ctrl
//
// Sequences a WIDTH-stage Johnson ring (2*WIDTH legal states) for a
// commanded number of steps. A start/steps command is accepted in IDLE.
// The ring then advances once per clock while the controller is in RUN.
// hold pauses the run for a cycle and abort ends it without a done pulse.
// Completion is signalled by a single-cycle done pulse. The ring state is
// also decoded to a one-hot phase vector for downstream multi-phase enables.
//
// Optional feature macro: JOHNSON_STEP_CTRL_DIR_EN
//   When it is defined, a 'dir' input is added and latched with start.
//   dir=0 steps the ring forward and dir=1 steps it in reverse.
//   When it is undefined, there is no dir port and the ring runs forward only.
//
// Parameters
//   WIDTH  Johnson stages (>= 2); the ring has 2*WIDTH states
//   CNT_W  width of the step-count command
//
// Ports
//   clk    in   1          clock; everything on the rising edge
//   reset  in   1          synchronous, active-high reset
//   start  in   1          command strobe; only honoured in IDLE
//   steps  in   CNT_W      ring advances requested; latched with start
//   hold   in   1          in RUN: skip this cycle's advance
//   abort  in   1          in RUN: return to IDLE without done
//   dir    in   1          (JOHNSON_STEP_CTRL_DIR_EN only) step direction
//   q      out  WIDTH      Johnson ring state (registered)
//   phase  out  2*WIDTH    one-hot position decoded from q
//   busy   out  1          high while in RUN (registered)
//   done   out  1          one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module johnson_step_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CNT_W-1:0]   steps,
    input  logic               hold,
    input  logic               abort,
`ifdef JOHNSON_STEP_CTRL_DIR_EN
    input  logic               dir,
`endif
    output logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] phase,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   q_next_s;
    logic [CNT_W-1:0]   rem_r;
    logic [CNT_W-1:0]   rem_next_s;
    logic               dir_r;
    logic               dir_next_s;
    logic               dir_in_s;
    logic               busy_r;
    logic               busy_next_s;
    logic               done_r;
    logic               done_next_s;

    // Forward Johnson step: shift left and feed back the inverted MSB.
    function automatic logic [WIDTH-1:0] step_fwd(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ~v[WIDTH-1]};
    endfunction

    // Reverse Johnson step: shift right and feed back the inverted LSB.
    function automatic logic [WIDTH-1:0] step_rev(input logic [WIDTH-1:0] v);
        return {~v[0], v[WIDTH-1:1]};
    endfunction

    // Map a ring state to its one-hot position.
    // On the filling half (MSB clear), the position is the number of ones.
    // On the draining half (MSB set), it counts down from 2*WIDTH.
    function automatic logic [2*WIDTH-1:0] decode_phase(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] onehot;
        int                 ones;
        int                 idx;
        ones = 32'sd0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(v[i]);
        end
        if (v[WIDTH-1]) begin
            idx = 2 * WIDTH - ones;
        end else begin
            idx = ones;
        end
        onehot = {{(2*WIDTH-1){1'b0}}, 1'b1} << idx;
        return onehot;
    endfunction

`ifdef JOHNSON_STEP_CTRL_DIR_EN
    assign dir_in_s = dir;
`else
    assign dir_in_s = 1'b0;
`endif

    // State, datapath and registered-output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            rem_r   <= CNT_ZERO;
            dir_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            q_r     <= q_next_s;
            rem_r   <= rem_next_s;
            dir_r   <= dir_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    // Next-state and datapath update. Within RUN, abort beats hold, and hold beats advance.
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        rem_next_s   = rem_r;
        dir_next_s   = dir_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (steps != CNT_ZERO) begin
                        state_next_s = ST_RUN;
                        rem_next_s   = steps;
                        dir_next_s   = dir_in_s;
                    end else begin
                        // A zero-length command completes at once and leaves q untouched.
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (hold) begin
                    state_next_s = ST_RUN;
                end else begin
                    if (dir_r) begin
                        q_next_s = step_rev(q_r);
                    end else begin
                        q_next_s = step_fwd(q_r);
                    end
                    rem_next_s = rem_r - CNT_ONE;
                    if (rem_r == CNT_ONE) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                // An unused encoding recovers to IDLE.
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so busy and done come out of flops.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_RUN: begin
                busy_next_s = 1'b1;
            end
            ST_DONE: begin
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    assign q     = q_r;
    assign phase = decode_phase(q_r);
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
